// File: rtl/key_rst_cond.sv
// key_rst_cond: push-button conditioner and stretched reset generator.
// Synchronises and debounces an active-low key, emits a one-cycle strobe per
// confirmed press, keeps a wrapping press counter (cpu_sel), and drives a
// registered, stretched active-high reset (rst_out) after rst_in release.
// Optional feature macro: LONG_PRESS_RST_EN. When defined, holding the key
// for LONG_CYCLES re-fires rst_out and clears cpu_sel once per press.
module key_rst_cond #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RST_CYCLES      = 15,
  parameter int SEL_WIDTH       = 2,
  parameter int LONG_CYCLES     = 200000000
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 key_n,
  output logic                 rst_out,
  output logic                 key_pulse,
  output logic                 key_level,
  output logic [SEL_WIDTH-1:0] cpu_sel
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RST_W = $clog2(RST_CYCLES + 1);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic [RST_W-1:0]       rst_cnt_q, rst_cnt_d;
  logic                   rst_out_q, rst_out_d;
  logic                   key_pulse_q, key_pulse_d;
  logic                   key_level_q, key_level_d;
  logic [SEL_WIDTH-1:0]   cpu_sel_q, cpu_sel_d;
  logic                   key_meta_q, key_sync_q;
  logic                   key_s;
  logic                   long_fire;

  assign key_s = key_sync_q;

`ifdef LONG_PRESS_RST_EN
  localparam int LONG_W = $clog2(LONG_CYCLES + 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

  logic [LONG_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              fired_q, fired_d;

  // Hold counter: runs in PRESSED, pauses in RELEASE_WAIT, clears once the
  // press is over; fired flag limits the trigger to one per press.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    fired_d    = fired_q;
    long_fire  = (state_q == PRESSED) && (hold_cnt_q == LONG_LAST) && !fired_q;
    case (state_q)
      PRESSED: begin
        if (hold_cnt_q != LONG_LAST) hold_cnt_d = hold_cnt_q + 1'b1;
      end
      RELEASE_WAIT: hold_cnt_d = hold_cnt_q;
      default:      hold_cnt_d = '0;
    endcase
    if (state_q == IDLE) fired_d = 1'b0;
    else if (long_fire)  fired_d = 1'b1;
  end

  // Hold counter and re-arm flag registers.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      hold_cnt_q <= '0;
      fired_q    <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      fired_q    <= fired_d;
    end
  end
`else
  // Long press is not built; a held key only keeps key_level high.
  logic [31:0] unused_long_cycles;
  assign unused_long_cycles = LONG_CYCLES;
  assign long_fire          = 1'b0;
`endif

  // Debounce FSM next state, debounce counter and key outputs.
  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    key_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!key_s) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = PRESSED;
          key_pulse_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (key_s) state_d = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (!key_s) begin
          state_d = PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A fresh debounce window starts on every state change.
    if (state_d != state_q) db_cnt_d = '0;
    key_level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  // Press counter and stretched reset counter.
  always_comb begin
    cpu_sel_d = cpu_sel_q;
    if (key_pulse_d) cpu_sel_d = cpu_sel_q + 1'b1;
    if (long_fire)   cpu_sel_d = '0;

    rst_cnt_d = (rst_cnt_q != '0) ? rst_cnt_q - 1'b1 : '0;
    if (long_fire) rst_cnt_d = RST_LOAD;
    rst_out_d = (rst_cnt_d != '0);
  end

  // All state registers; rst_in clears asynchronously, rst_out never feeds back.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      key_meta_q  <= 1'b1;
      key_sync_q  <= 1'b1;
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      key_pulse_q <= 1'b0;
      key_level_q <= 1'b0;
      cpu_sel_q   <= '0;
      rst_cnt_q   <= RST_LOAD;
      rst_out_q   <= 1'b1;
    end else begin
      key_meta_q  <= key_n;
      key_sync_q  <= key_meta_q;
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      key_pulse_q <= key_pulse_d;
      key_level_q <= key_level_d;
      cpu_sel_q   <= cpu_sel_d;
      rst_cnt_q   <= rst_cnt_d;
      rst_out_q   <= rst_out_d;
    end
  end

  assign rst_out   = rst_out_q;
  assign key_pulse = key_pulse_q;
  assign key_level = key_level_q;
  assign cpu_sel   = cpu_sel_q;

endmodule

// File: tb/tb_key_rst_cond.sv
// Directed bench for key_rst_cond with short debounce/reset/long-press timing.
// Edge numbering: "edge 0" is the first rising edge after an input change.
module tb_key_rst_cond;

  localparam int DEBOUNCE_CYCLES = 4;
  localparam int RST_CYCLES      = 15;
  localparam int SEL_WIDTH       = 2;
  localparam int LONG_CYCLES     = 20;

  logic                 clk = 1'b0;
  logic                 rst_in = 1'b0;
  logic                 key_n = 1'b1;
  logic                 rst_out;
  logic                 key_pulse;
  logic                 key_level;
  logic [SEL_WIDTH-1:0] cpu_sel;

  int tests = 0;
  int fails = 0;

  key_rst_cond #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RST_CYCLES     (RST_CYCLES),
    .SEL_WIDTH      (SEL_WIDTH),
    .LONG_CYCLES    (LONG_CYCLES)
  ) dut (
    .clk      (clk),
    .rst_in   (rst_in),
    .key_n    (key_n),
    .rst_out  (rst_out),
    .key_pulse(key_pulse),
    .key_level(key_level),
    .cpu_sel  (cpu_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    step();
    step();
    rst_in = 1'b1;
    repeat (16) step();
  endtask

  initial begin
    int npulse;
    logic [31:0] exp_rst;
    logic [31:0] exp_sel;

    // Reset state and rst_out stretch
    repeat (3) step();
    chk("rst_hold_rst_out", 32'(rst_out), 32'd1);
    chk("rst_hold_pulse", 32'(key_pulse), 32'd0);
    chk("rst_hold_level", 32'(key_level), 32'd0);
    chk("rst_hold_sel", 32'(cpu_sel), 32'd0);
    rst_in = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("stretch_rst_out", 32'(rst_out), 32'(k < RST_CYCLES));
      chk("stretch_pulse", 32'(key_pulse), 32'd0);
      chk("stretch_level", 32'(key_level), 32'd0);
      chk("stretch_sel", 32'(cpu_sel), 32'd0);
    end

    // Single clean press held
    key_n = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      step();
      chk("press_pulse", 32'(key_pulse), 32'(k == 6));
      chk("press_level", 32'(key_level), 32'(k >= 6));
      chk("press_sel", 32'(cpu_sel), 32'(k >= 6));
    end
    key_n = 1'b1;
    repeat (10) step();
    chk("release_level", 32'(key_level), 32'd0);
    chk("release_sel", 32'(cpu_sel), 32'd1);

    // Short bounces are rejected
    do_reset();
    for (int r = 0; r < 5; r++) begin
      key_n = 1'b0;
      repeat (3) begin
        step();
        chk("bounce_pulse", 32'(key_pulse), 32'd0);
        chk("bounce_level", 32'(key_level), 32'd0);
      end
      key_n = 1'b1;
      repeat (3) begin
        step();
        chk("bounce_pulse", 32'(key_pulse), 32'd0);
        chk("bounce_level", 32'(key_level), 32'd0);
      end
    end
    chk("bounce_sel", 32'(cpu_sel), 32'd0);

    // Four clean presses wrap cpu_sel
    do_reset();
    npulse = 0;
    for (int i = 0; i < 4; i++) begin
      key_n = 1'b0;
      repeat (10) begin
        step();
        if (key_pulse) npulse++;
      end
      chk("wrap_sel", 32'(cpu_sel), 32'((i + 1) % 4));
      key_n = 1'b1;
      repeat (10) begin
        step();
        if (key_pulse) npulse++;
      end
    end
    chk("wrap_pulse_count", 32'(npulse), 32'd4);

    // rst_in mid-hold aborts, then a fresh press is confirmed
    do_reset();
    key_n = 1'b0;
    repeat (8) step();
    chk("midhold_pre_sel", 32'(cpu_sel), 32'd1);
    chk("midhold_pre_level", 32'(key_level), 32'd1);
    rst_in = 1'b0;
    #1;
    chk("midhold_async_level", 32'(key_level), 32'd0);
    chk("midhold_async_pulse", 32'(key_pulse), 32'd0);
    chk("midhold_async_sel", 32'(cpu_sel), 32'd0);
    chk("midhold_async_rst_out", 32'(rst_out), 32'd1);
    step();
    step();
    rst_in = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      step();
      chk("repress_pulse", 32'(key_pulse), 32'(k == 6));
      chk("repress_sel", 32'(cpu_sel), 32'(k >= 6));
      chk("repress_rst_out", 32'(rst_out), 32'd1);
    end

    // rst_in during debounce window: no pulse, no count
    do_reset();
    key_n = 1'b0;
    repeat (4) step();
    rst_in = 1'b0;
    #1;
    chk("pw_abort_sel", 32'(cpu_sel), 32'd0);
    key_n = 1'b1;
    step();
    rst_in = 1'b1;
    repeat (10) begin
      step();
      chk("pw_abort_pulse", 32'(key_pulse), 32'd0);
    end
    chk("pw_abort_sel_after", 32'(cpu_sel), 32'd0);

    // Long hold: confirm at edge 6, trigger behaviour depends on build
    do_reset();
    key_n = 1'b0;
    for (int k = 0; k <= 50; k++) begin
      step();
`ifdef LONG_PRESS_RST_EN
      exp_rst = 32'((k >= 26) && (k <= 40));
      exp_sel = 32'((k >= 6) && (k < 26));
`else
      exp_rst = 32'd0;
      exp_sel = 32'(k >= 6);
`endif
      chk("long_rst_out", 32'(rst_out), exp_rst);
      chk("long_sel", 32'(cpu_sel), exp_sel);
      chk("long_pulse", 32'(key_pulse), 32'(k == 6));
      chk("long_level", 32'(key_level), 32'(k >= 6));
    end
    key_n = 1'b1;
    repeat (10) step();
    chk("long_release_level", 32'(key_level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
